// File: rtl/iop_bus_pkg.sv
// iop_bus_pkg: shared definitions for the IOP408 bus arbiter and its round-robin picker.
//   - FSM state encoding (IDLE/BUSY/RESP) and the matching state_t enum
//   - requester index constants (IFU, LSU, DMA)
//   - read data returned on a timed-out transaction
//   - wrap_inc(): modulo-n increment of a requester index
package iop_bus_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_BUSY = BUSY,
        S_RESP = RESP
    } state_t;

    localparam int REQ_IFU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_DMA = 2;

    // Requester indices are carried in IDX_W bits; up to MAX_REQ requesters.
    localparam int IDX_W   = 2;
    localparam int MAX_REQ = 4;

    localparam logic [7:0] ERR_RDATA = 8'hFF;

    // (idx + 1) mod n, valid for idx < n <= MAX_REQ.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input int unsigned n);
        logic [IDX_W-1:0] nxt;
        nxt = idx + 1'b1;
        if (32'(idx) + 32'd1 >= n) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/iop_rr_pick.sv
// iop_rr_pick: combinational round-robin picker.
// Returns the first pending index at or after i_rr_ptr, wrapping modulo NREQ.
// Ports:
//   i_pending  [NREQ]   one bit per requester with an outstanding request
//   i_rr_ptr   [IDX_W]  index with highest priority this round (must be < NREQ)
//   o_grant    [IDX_W]  selected index (0 when nothing is pending)
//   o_any      [1]      at least one requester is pending
module iop_rr_pick
    import iop_bus_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]  i_pending,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any
);

    // Pad to MAX_REQ so the IDX_W-bit walking index always addresses a real bit.
    logic [MAX_REQ-1:0] w_pend;
    logic [IDX_W-1:0]   w_idx;

    always_comb begin
        w_pend           = '0;
        w_pend[NREQ-1:0] = i_pending;
        w_idx            = i_rr_ptr;
        o_grant          = '0;
        o_any            = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!o_any && w_pend[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
            w_idx = wrap_inc(w_idx, NREQ);
        end
    end

endmodule

// File: rtl/iop_bus_arbiter.sv
// iop_bus_arbiter: round-robin arbiter for the IOP408 8-bit data / 16-bit address bus.
// One transaction in flight; IDLE -> BUSY (strobes live until rdy or timeout) -> RESP (ok pulse).
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_read/i_req_write  [NREQ]     per-requester strobes, held until that requester's ok
//   i_req_addr              [16*NREQ]  packed addresses, slice i = [16i+15:16i]
//   i_req_wdata             [8*NREQ]   packed write data
//   o_req_ok                [NREQ]     one-cycle completion pulse, one-hot or zero
//   o_req_rdata             [8]        registered read data, valid with o_req_ok
//   o_req_err               [1]        transaction timed out, valid with o_req_ok
//   o_addr, o_wdata, o_read, o_write   bus master outputs
//   i_rdata, i_rdy                     bus slave read data and ready
module iop_bus_arbiter
    import iop_bus_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req_read,
    input  logic [NREQ-1:0]      i_req_write,
    input  logic [16*NREQ-1:0]   i_req_addr,
    input  logic [8*NREQ-1:0]    i_req_wdata,
    output logic [NREQ-1:0]      o_req_ok,
    output logic [7:0]           o_req_rdata,
    output logic                 o_req_err,
    output logic [15:0]          o_addr,
    output logic [7:0]           o_wdata,
    output logic                 o_read,
    output logic                 o_write,
    input  logic [7:0]           i_rdata,
    input  logic                 i_rdy
);

    state_t           r_state, w_state_d;
    logic [IDX_W-1:0] r_grant, w_grant_d;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_d;
    logic [TO_W-1:0]  r_cnt, w_cnt_d;
    logic [7:0]       r_rdata, w_rdata_d;
    logic             r_err, w_err_d;
    logic             r_bubble, w_bubble_d;

    logic [NREQ-1:0]  w_pending;
    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic             w_gnt_rd;
    logic             w_gnt_wr;

    assign w_pending = i_req_read | i_req_write;
    assign w_gnt_rd  = i_req_read[r_grant];
    assign w_gnt_wr  = i_req_write[r_grant];

    iop_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_pending (w_pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant   (w_pick),
        .o_any     (w_any)
    );

    always_comb begin
        w_state_d  = r_state;
        w_grant_d  = r_grant;
        w_rr_d     = r_rr_ptr;
        w_cnt_d    = r_cnt;
        w_rdata_d  = r_rdata;
        w_err_d    = r_err;
        w_bubble_d = 1'b0;
        o_addr     = '0;
        o_wdata    = '0;
        o_read     = 1'b0;
        o_write    = 1'b0;
        o_req_ok   = '0;
        unique case (r_state)
            S_IDLE: begin
                // The IDLE cycle right after RESP never grants: it is the slot in which the
                // served requester drops or replaces its still-held request.
                if (!r_bubble && w_any) begin
                    w_grant_d = w_pick;
                    w_rr_d    = wrap_inc(w_pick, NREQ);
                    w_cnt_d   = '0;
                    w_state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Address/data are live: the requester holds them stable until ok.
                o_addr  = i_req_addr[{r_grant, 4'b0000} +: 16];
                o_wdata = i_req_wdata[{r_grant, 3'b000} +: 8];
                o_write = w_gnt_wr;
                o_read  = w_gnt_rd & ~w_gnt_wr;
                w_cnt_d = r_cnt + 1'b1;
                if (!(w_gnt_rd || w_gnt_wr)) begin
                    // Request withdrawn mid-transaction: abandon it silently.
                    w_cnt_d   = '0;
                    w_state_d = S_IDLE;
                end else if (i_rdy) begin
                    w_rdata_d = i_rdata;
                    w_err_d   = 1'b0;
                    w_state_d = S_RESP;
                end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_rdata_d = ERR_RDATA;
                    w_err_d   = 1'b1;
                    w_state_d = S_RESP;
                end
            end
            S_RESP: begin
                o_req_ok[r_grant] = 1'b1;
                w_cnt_d           = '0;
                w_err_d           = 1'b0;
                w_bubble_d        = 1'b1;
                w_state_d         = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign o_req_rdata = r_rdata;
    assign o_req_err   = r_err & (r_state == S_RESP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= IDX_W'(REQ_IFU);
            r_rr_ptr <= IDX_W'(REQ_IFU);
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_bubble <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_grant  <= w_grant_d;
            r_rr_ptr <= w_rr_d;
            r_cnt    <= w_cnt_d;
            r_rdata  <= w_rdata_d;
            r_err    <= w_err_d;
            r_bubble <= w_bubble_d;
        end
    end

endmodule
